ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the EX stage of the five-stage pipeline, alongside the integer ALU.
- Consumes the forwarded rs1/rs2 operands produced by the EX operand-forwarding mux.
- Holds the pipeline via a stall request while it iterates, then returns a registered result to the EX/MEM path.
- Fixed latency for every operation: one shift-add or shift-subtract step per cycle.

Parameters:
- REG_WIDTH, 64, operand and result width in bits (XLEN).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX holds a valid M-extension instruction
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  REG_WIDTH  forwarded rs1
- op_b  input  REG_WIDTH  forwarded rs2
- flush  input  1  kill the in-flight operation (branch mispredict or trap)
- busy  output  1  operation in progress
- stall_req  output  1  freeze IF/ID/EX
- done  output  1  one-cycle result-valid pulse
- result  output  REG_WIDTH  final result, held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, and all internal accumulators and counters are 0.
- States: IDLE, PREP, CALC, FIXUP, DONE.
- Start acceptance: start is accepted only in IDLE or DONE, with flush=0. funct3, op_a and op_b are latched on that edge (E0). The next state is PREP.
- start while busy=1 is ignored.
- PREP, 1 cycle:
  - Record operand signs per funct3. MULH and DIV/REM treat both operands as signed. MULHSU treats op_a as signed and op_b as unsigned. All other ops are unsigned.
  - Take operand magnitudes.
  - Detect divide-by-zero (op_b==0) and signed overflow (op_a = most negative, op_b = all ones, signed div/rem).
  - Clear the 2*REG_WIDTH accumulator and set count=0.
- CALC, exactly REG_WIDTH cycles:
  - Multiply: shift-add, one multiplier bit per cycle, into the 2*REG_WIDTH product.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Leave CALC when count == REG_WIDTH-1.
- FIXUP, 1 cycle: apply the sign correction, then select the result.
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register the selected value into result.
- Special cases, which override the arithmetic and follow RISC-V M semantics:
  - Divide-by-zero: quotient = all ones; remainder = op_a.
  - Signed overflow: quotient = op_a; remainder = 0.
- DONE, 1 cycle: done=1, then return to IDLE. A start accepted in DONE goes directly to PREP (back-to-back).
- Latency: done is high in the cycle after edge E0+REG_WIDTH+2. Special cases do not shorten it.
- busy=1 in PREP, CALC and FIXUP only; 0 in IDLE and DONE.
- stall_req = busy | (start & (state is IDLE or DONE) & ~flush). This is combinational, so EX freezes in the same cycle the instruction arrives and releases in the DONE cycle.
- Flush:
  - flush=1 in any state forces IDLE on the next edge; done is not asserted.
  - result keeps its previous value.
  - start is ignored while flush=1.
  - Flush has priority over the DONE→PREP start.
- Reset mid-operation: immediate return to IDLE; all outputs return to their reset values.
- Operand changes after E0 have no effect, because latched copies are used.

Optional Feature:
- Macro: MULDIV_WORD_OPS_EN.
- With the macro defined:
  - Extra port: word, input, 1 bit, latched at start, selecting MULW/DIVW/DIVUW/REMW/REMUW.
  - Operands are the low 32 bits, sign- or zero-extended per op.
  - The 32-bit result is sign-extended to REG_WIDTH.
  - Special cases are evaluated on 32-bit values. Latency is unchanged.
  - word=1 with funct3 001/010/011 is illegal; result is undefined but done still pulses.
  - Requires REG_WIDTH=64.
- Without the macro: no word port; all ops are full REG_WIDTH.

Test Plan:
- MUL, op_a=7, op_b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> done exactly 66 edges after start is sampled; result=0xFFFF_FFFF_FFFF_FFEB; stall_req high from the start cycle through the cycle before done.
- MULHU, op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands -> result=0.
- DIV, op_a=-20, op_b=6 -> result=-3. REM on the same operands -> result=-2. DIVU, op_a=20, op_b=6 -> result=3.
- DIV by zero, op_a=42 -> result=0xFFFF_FFFF_FFFF_FFFF. REM by zero -> 42. DIV with op_a=0x8000_0000_0000_0000, op_b=-1 -> result=0x8000_0000_0000_0000. REM on the same operands -> 0. Each with a 66-edge latency.
- Start DIV, assert flush at CALC cycle 10 -> IDLE next edge; no done pulse; result unchanged. New MUL 5×5 started the following cycle -> result=25.
- Back-to-back: start held in the DONE cycle with a second MUL -> second done 66 edges later. rst_n pulsed low mid-CALC -> busy/done/result=0 asynchronously; next op completes correctly.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage: fixed REG_WIDTH+3 cycle latency, stall request while busy.
// Define MULDIV_WORD_OPS_EN to add the 'word' input for the RV64 *W operations (requires REG_WIDTH=64).
module ex_muldiv_unit #(
   parameter int REG_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           funct3,
   input  logic [REG_WIDTH-1:0] op_a,
   input  logic [REG_WIDTH-1:0] op_b,
`ifdef MULDIV_WORD_OPS_EN
   input  logic                 word,
`endif
   input  logic                 flush,
   output logic                 busy,
   output logic                 stall_req,
   output logic                 done,
   output logic [REG_WIDTH-1:0] result
);

   localparam int W  = REG_WIDTH;
   localparam int CW = $clog2(REG_WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(REG_WIDTH - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_CALC  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]     r_state;
   logic [2:0]     r_f3;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_opnd;
   logic [W-1:0]   r_sh;
   logic [W-1:0]   r_result;
   logic [2*W-1:0] r_acc;
   logic [CW-1:0]  r_cnt;
   logic           r_neg_a;
   logic           r_neg_b;
   logic           r_dbz;
   logic           r_ovf;
`ifdef MULDIV_WORD_OPS_EN
   logic           r_word;
`endif

   logic           w_idle_or_done;
   logic           w_sgn_a;
   logic           w_sgn_b;
   logic           w_neg_a;
   logic           w_neg_b;
   logic [W-1:0]   w_mag_a;
   logic [W-1:0]   w_mag_b;
   logic [W:0]     w_add;
   logic [W:0]     w_rem_sh;
   logic [W:0]     w_diff;
   logic           w_qbit;
   logic [2*W-1:0] w_prod;
   logic [W-1:0]   w_quo;
   logic [W-1:0]   w_rem_raw;
   logic [W-1:0]   w_rem;
   logic [W-1:0]   w_sel;
   logic [W-1:0]   w_final;

`ifdef MULDIV_WORD_OPS_EN
   function automatic logic [W-1:0] ext_word(input logic [W-1:0] v, input logic sx);
      return {{(W-32){sx & v[31]}}, v[31:0]};
   endfunction
`endif

   assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
   assign busy           = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIXUP);
   assign done           = (r_state == S_DONE);
   assign stall_req      = busy | (start & w_idle_or_done & ~flush);
   assign result         = r_result;

   assign w_sgn_a = (r_f3 == 3'b001) || (r_f3 == 3'b010) || (r_f3 == 3'b100) || (r_f3 == 3'b110);
   assign w_sgn_b = (r_f3 == 3'b001) || (r_f3 == 3'b100) || (r_f3 == 3'b110);
   assign w_neg_a = w_sgn_a & r_a[W-1];
   assign w_neg_b = w_sgn_b & r_b[W-1];
   assign w_mag_a = w_neg_a ? -r_a : r_a;
   assign w_mag_b = w_neg_b ? -r_b : r_b;

   // Multiply: r_opnd is the multiplicand, r_sh shifts out multiplier bits LSB first.
   assign w_add    = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_sh[0] ? r_opnd : {W{1'b0}})};
   // Divide: r_opnd is the divisor, r_sh shifts dividend bits out and quotient bits in.
   assign w_rem_sh = {r_acc[2*W-1:W], r_sh[W-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_opnd};
   assign w_qbit   = ~w_diff[W];

   assign w_prod    = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
   assign w_quo     = (r_neg_a ^ r_neg_b) ? -r_sh : r_sh;
   assign w_rem_raw = r_acc[2*W-1:W];
   assign w_rem     = r_neg_a ? -w_rem_raw : w_rem_raw;

   always_comb begin
      w_sel = w_prod[W-1:0];
      case (r_f3)
         3'b000:                 w_sel = w_prod[W-1:0];
         3'b001, 3'b010, 3'b011: w_sel = w_prod[2*W-1:W];
         3'b100, 3'b101:         w_sel = r_dbz ? {W{1'b1}} : (r_ovf ? r_a : w_quo);
         default:                w_sel = r_dbz ? r_a : (r_ovf ? {W{1'b0}} : w_rem);
      endcase
   end

`ifdef MULDIV_WORD_OPS_EN
   assign w_final = r_word ? ext_word(w_sel, 1'b1) : w_sel;
`else
   assign w_final = w_sel;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_f3     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_opnd   <= '0;
         r_sh     <= '0;
         r_result <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
`ifdef MULDIV_WORD_OPS_EN
         r_word   <= 1'b0;
`endif
      end else if (flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_f3    <= funct3;
`ifdef MULDIV_WORD_OPS_EN
                  r_word  <= word;
                  r_a     <= word ? ext_word(op_a, ~funct3[0]) : op_a;
                  r_b     <= word ? ext_word(op_b, ~funct3[0]) : op_b;
`else
                  r_a     <= op_a;
                  r_b     <= op_b;
`endif
                  r_state <= S_PREP;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_PREP: begin
               r_neg_a <= w_neg_a;
               r_neg_b <= w_neg_b;
               r_dbz   <= (r_b == '0);
               r_ovf   <= r_f3[2] & ~r_f3[0] & (r_a == {1'b1, {(W-1){1'b0}}}) & (&r_b);
               r_opnd  <= r_f3[2] ? w_mag_b : w_mag_a;
               r_sh    <= r_f3[2] ? w_mag_a : w_mag_b;
               r_acc   <= '0;
               r_cnt   <= '0;
               r_state <= S_CALC;
            end
            S_CALC: begin
               if (r_f3[2]) begin
                  r_acc <= {(w_qbit ? w_diff[W-1:0] : w_rem_sh[W-1:0]), {W{1'b0}}};
                  r_sh  <= {r_sh[W-2:0], w_qbit};
               end else begin
                  r_acc <= {w_add, r_acc[W-1:1]};
                  r_sh  <= {1'b0, r_sh[W-1:1]};
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) r_state <= S_FIXUP;
            end
            S_FIXUP: begin
               r_result <= w_final;
               r_state  <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model plus per-cycle timeline checker.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

   localparam int W = 64;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        busy;
   logic        stall_req;
   logic        done;
   logic [63:0] result;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.REG_WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .funct3(funct3),
      .op_a(op_a),
      .op_b(op_b),
`ifdef MULDIV_WORD_OPS_EN
      .word(1'b0),
`endif
      .flush(flush),
      .busy(busy),
      .stall_req(stall_req),
      .done(done),
      .result(result)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RISC-V M semantics computed with wide plain arithmetic.
   function automatic logic [63:0] ref_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa_w, sb_w, ua_w, ub_w, p;
      longint sa, sb;
      sa_w = {{64{a[63]}}, a};
      sb_w = {{64{b[63]}}, b};
      ua_w = {64'd0, a};
      ub_w = {64'd0, b};
      sa = a;
      sb = b;
      case (f)
         3'b000: begin p = ua_w * ub_w; return p[63:0]; end
         3'b001: begin p = sa_w * sb_w; return p[127:64]; end
         3'b010: begin p = sa_w * ub_w; return p[127:64]; end
         3'b011: begin p = ua_w * ub_w; return p[127:64]; end
         3'b100: begin
            if (b == 64'd0) return ONES;
            else if (a == MIN64 && b == ONES) return a;
            else return 64'(sa / sb);
         end
         3'b101: return (b == 64'd0) ? ONES : a / b;
         3'b110: begin
            if (b == 64'd0) return a;
            else if (a == MIN64 && b == ONES) return 64'd0;
            else return 64'(sa % sb);
         end
         default: return (b == 64'd0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return ONES;
         2: return MIN64;
         3: return 64'($urandom_range(0, 20));
         4: return -64'($urandom_range(1, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Timeline model: edges elapsed since acceptance; busy for 0..65, done at 66.
   bit          m_act = 1'b0;
   int          m_el  = 0;
   logic [63:0] m_exp = '0;
   logic [63:0] m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act = 1'b0;
         m_el  = 0;
         m_res = '0;
      end else if (flush) begin
         m_act = 1'b0;
      end else if (m_act && m_el < 66) begin
         m_el++;
         if (m_el == 66) m_res = m_exp;
      end else if (start) begin
         m_act = 1'b1;
         m_el  = 0;
         m_exp = ref_op(funct3, op_a, op_b);
      end else begin
         m_act = 1'b0;
      end
   end

   always @(negedge clk) begin : monitor
      logic eb, ed, es;
      eb = m_act && (m_el <= 65);
      ed = m_act && (m_el == 66);
      es = eb | (start & ~flush);
      chk("busy", 64'(busy), 64'(eb));
      chk("done", 64'(done), 64'(ed));
      chk("stall_req", 64'(stall_req), 64'(es));
      chk("result", result, m_res);
   end

   // Called at #1 after a rising edge with the unit idle or in DONE.
   task automatic do_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input bit noisy,
                        output logic [63:0] r, output int lat);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      @(posedge clk); #1;
      lat    = 0;
      start  = 1'b0;
      funct3 = 3'($urandom);
      op_a   = {$urandom, $urandom};
      op_b   = {$urandom, $urandom};
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
         start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start = 1'b0;
      r = result;
   endtask

   task automatic do_dir(input string name, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
      logic [63:0] r;
      int lat;
      do_op(f, a, b, 1'b0, r, lat);
      chk({name, "_res"}, r, exp);
      chk({name, "_lat"}, 64'(lat), 64'd66);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] r;
      int lat;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;

      chk("model_mul",   ref_op(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
      chk("model_mulhu", ref_op(3'b011, ONES, ONES), 64'hFFFF_FFFF_FFFF_FFFE);
      chk("model_div",   ref_op(3'b100, -64'd20, 64'd6), -64'd3);
      chk("model_rem",   ref_op(3'b110, -64'd20, 64'd6), -64'd2);
      chk("model_ovf",   ref_op(3'b100, MIN64, ONES), MIN64);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_dir("mul",       3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      do_dir("mulhu",     3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
      do_dir("mulh",      3'b001, ONES, ONES, 64'd0);
      do_dir("div",       3'b100, -64'd20, 64'd6, -64'd3);
      do_dir("rem",       3'b110, -64'd20, 64'd6, -64'd2);
      do_dir("divu",      3'b101, 64'd20, 64'd6, 64'd3);
      do_dir("div_zero",  3'b100, 64'd42, 64'd0, ONES);
      do_dir("rem_zero",  3'b110, 64'd42, 64'd0, 64'd42);
      do_dir("rem_ovf",   3'b110, MIN64, ONES, 64'd0);
      do_dir("div_ovf",   3'b100, MIN64, ONES, MIN64);

      // Flush mid-CALC: no done, result keeps the last value.
      start = 1'b1; funct3 = 3'b100; op_a = 64'd100; op_b = 64'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_done", 64'(done), 64'd0);
      chk("flush_result", result, MIN64);
      do_dir("mul_after_flush", 3'b000, 64'd5, 64'd5, 64'd25);

      // Back-to-back: second start presented in the DONE cycle.
      do_op(3'b000, 64'd11, 64'd3, 1'b0, r, lat);
      chk("b2b_first_res", r, 64'd33);
      do_op(3'b000, 64'd6, 64'd7, 1'b0, r, lat);
      chk("b2b_second_res", r, 64'd42);
      chk("b2b_second_lat", 64'(lat), 64'd66);

      // Flush beats a start held in the DONE cycle.
      start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 64'd9; op_b = 64'd9;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_pri_busy", 64'(busy), 64'd0);
      chk("flush_pri_result", result, 64'd42);
      repeat (2) begin @(posedge clk); #1; end

      // Asynchronous reset mid-CALC.
      start = 1'b1; funct3 = 3'b101; op_a = 64'd1000; op_b = 64'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_result", result, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_dir("after_reset", 3'b101, 64'd1000, 64'd3, 64'd333);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f;
         logic [63:0] a, b, e;
         f = 3'($urandom_range(0, 7));
         a = rnd64();
         b = rnd64();
         e = ref_op(f, a, b);
         do_op(f, a, b, 1'b1, r, lat);
         chk("rand_res", r, e);
         chk("rand_lat", 64'(lat), 64'd66);
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
